// File: rtl/idma_obi_sub_pkg.sv
// Shared types and helpers for the OBI subordinate SRAM adapter.
package idma_obi_sub_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultIdWidth   = 1;

  // Response entry layout; the top re-declares it at its own parameter widths.
  typedef struct packed {
    logic [DefaultDataWidth-1:0] rdata;
    logic                        err;
    logic [DefaultIdWidth-1:0]   rid;
  } resp_entry_t;

  function automatic int unsigned word_off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Register-based FIFO with optional fall-through, port-compatible with common_cells fifo_v3.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned             FifoDepth = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [ADDR_DEPTH-1:0]   LastPtr   = ADDR_DEPTH'(FifoDepth - 1);
  localparam logic [ADDR_DEPTH-1:0]   PtrOne    = ADDR_DEPTH'(1);
  localparam logic [ADDR_DEPTH:0]     FullCount = (ADDR_DEPTH + 1)'(FifoDepth);
  localparam logic [ADDR_DEPTH:0]     CountOne  = (ADDR_DEPTH + 1)'(1);

  logic [ADDR_DEPTH-1:0] r_rd_ptr;
  logic [ADDR_DEPTH-1:0] r_wr_ptr;
  logic [ADDR_DEPTH:0]   r_count;
  dtype                  r_mem [FifoDepth];
  logic                  w_is_empty;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_testmode_unused;

  assign w_testmode_unused = testmode_i;
  assign w_is_empty        = (r_count == '0);
  assign full_o            = (r_count == FullCount);
  assign usage_o           = r_count[ADDR_DEPTH-1:0];
  assign empty_o           = w_is_empty & ~(FALL_THROUGH & push_i);

  // A push into an empty fall-through FIFO is visible at once and, if popped, never stored.
  assign w_bypass = FALL_THROUGH & w_is_empty & push_i & pop_i;
  assign data_o   = (FALL_THROUGH && w_is_empty) ? data_i : r_mem[r_rd_ptr];
  assign w_push   = push_i & ~full_o & ~w_bypass;
  assign w_pop    = pop_i & ~w_is_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrOne;
      if (w_push && !w_pop)      r_count <= r_count + CountOne;
      else if (!w_push && w_pop) r_count <= r_count - CountOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem <= '{default: '0};
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/idma_obi_sub_sram.sv
// OBI subordinate in front of a single-cycle SRAM: grants bounded by outstanding
// responses, one-stage read pipeline, in-order response FIFO.
module idma_obi_sub_sram
  import idma_obi_sub_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned IdWidth      = 1,
  parameter int unsigned MemSizeBytes = 4096,
  parameter int unsigned RespDepth    = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          req_i,
  output logic                                          gnt_o,
  input  logic [AddrWidth-1:0]                          addr_i,
  input  logic                                          we_i,
  input  logic [DataWidth/8-1:0]                        be_i,
  input  logic [DataWidth-1:0]                          wdata_i,
  input  logic [IdWidth-1:0]                            aid_i,
  output logic                                          rvalid_o,
  input  logic                                          rready_i,
  output logic [DataWidth-1:0]                          rdata_o,
  output logic                                          err_o,
  output logic [IdWidth-1:0]                            rid_o,
  output logic                                          mem_req_o,
  output logic                                          mem_we_o,
  output logic [AddrWidth-word_off_bits(DataWidth)-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]                        mem_be_o,
  output logic [DataWidth-1:0]                          mem_wdata_o,
  input  logic [DataWidth-1:0]                          mem_rdata_i
);

  localparam int unsigned         OffBits    = word_off_bits(DataWidth);
  localparam int unsigned         CntWidth   = $clog2(RespDepth + 1);
  localparam int unsigned         UsageWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [CntWidth-1:0] CntMax     = CntWidth'(RespDepth);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);
  localparam logic [AddrWidth:0]  MemLimit   = (AddrWidth + 1)'(MemSizeBytes);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic [IdWidth-1:0]   rid;
  } resp_t;

  logic [CntWidth-1:0]   r_cnt;
  logic                  r_pipe_valid;
  logic                  r_pipe_we;
  logic                  r_pipe_err;
  logic [IdWidth-1:0]    r_pipe_id;
  logic                  w_a_hs;
  logic                  w_r_hs;
  logic                  w_addr_err;
  logic                  w_fifo_empty;
  logic                  w_fifo_full_unused;
  logic [UsageWidth-1:0] w_fifo_usage_unused;
  logic                  w_unused_addr_lsb;
  resp_t                 w_push_entry;
  resp_t                 w_pop_entry;

  assign w_unused_addr_lsb = ^addr_i;
  assign w_addr_err        = ({1'b0, addr_i} >= MemLimit);

  // Grant only while a response slot is free; a same-cycle R handshake does not free one.
  assign gnt_o  = rst_ni & req_i & (r_cnt < CntMax);
  assign w_a_hs = req_i & gnt_o;
  assign w_r_hs = rvalid_o & rready_i;

  assign mem_req_o   = w_a_hs & ~w_addr_err;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = addr_i[AddrWidth-1:OffBits];
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_a_hs && !w_r_hs) begin
      r_cnt <= r_cnt + CntOne;
    end else if (!w_a_hs && w_r_hs) begin
      r_cnt <= r_cnt - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_valid <= 1'b0;
      r_pipe_we    <= 1'b0;
      r_pipe_err   <= 1'b0;
      r_pipe_id    <= '0;
    end else begin
      r_pipe_valid <= w_a_hs;
      if (w_a_hs) begin
        r_pipe_we  <= we_i;
        r_pipe_err <= w_addr_err;
        r_pipe_id  <= aid_i;
      end
    end
  end

  // SRAM read data is only meaningful for in-range reads; everything else answers zero.
  assign w_push_entry = '{
    rdata: (!r_pipe_we && !r_pipe_err) ? mem_rdata_i : '0,
    err:   r_pipe_err,
    rid:   r_pipe_id
  };

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   ($bits(resp_t)),
    .DEPTH        (RespDepth),
    .dtype        (resp_t)
  ) i_resp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (w_fifo_full_unused),
    .empty_o    (w_fifo_empty),
    .usage_o    (w_fifo_usage_unused),
    .data_i     (w_push_entry),
    .push_i     (r_pipe_valid),
    .data_o     (w_pop_entry),
    .pop_i      (rready_i)
  );

  assign rvalid_o = ~w_fifo_empty;
  assign rdata_o  = rvalid_o ? w_pop_entry.rdata : '0;
  assign err_o    = rvalid_o & w_pop_entry.err;
  assign rid_o    = rvalid_o ? w_pop_entry.rid : '0;

endmodule

// File: tb/tb_idma_obi_sub_sram.sv
// Self-checking bench: directed OBI scenarios plus random traffic against a
// transaction-level model (byte-addressed reference memory and in-order response queue).
module tb_idma_obi_sub_sram;

  localparam int MemBytes = 4096;
  localparam int Depth    = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic [0:0]  aid_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [0:0]  rid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  idma_obi_sub_sram #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .IdWidth      (1),
    .MemSizeBytes (MemBytes),
    .RespDepth    (Depth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .aid_i       (aid_i),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .rid_o       (rid_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [0:0]  rid;
    int          readyCyc;
  } expResp_t;

  expResp_t    expQ[$];
  logic [31:0] refMem [1024];
  logic [31:0] sram [1024];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          outstanding = 0;
  int          dutGrants = 0;
  logic        expGnt;
  logic        lastGnt;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic [0:0]  lastRid;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata, input logic [0:0] aid);
    req_i   = req;
    addr_i  = addr;
    we_i    = we;
    be_i    = be;
    wdata_i = wdata;
    aid_i   = aid;
  endtask

  // One clock: check at the falling edge, advance the model, then play the SRAM after the rising edge.
  task automatic runCycle();
    logic        inRange;
    logic        frontReady;
    logic        envReq;
    logic        envWe;
    logic [9:0]  envIdx;
    logic [3:0]  envBe;
    logic [31:0] envWdata;
    logic [31:0] rdWord;
    expResp_t    ent;
    @(negedge clk);
    expGnt  = (rst_ni === 1'b1) && (req_i === 1'b1) && (outstanding < Depth);
    lastGnt = gnt_o;
    if (gnt_o === 1'b1) dutGrants++;
    checkOutput("gnt", gnt_o, expGnt);
    if (rst_ni !== 1'b1) begin
      checkOutput("rst_rdata", rdata_o, '0);
      checkOutput("rst_err", err_o, '0);
      checkOutput("rst_rid", rid_o, '0);
    end
    frontReady = (expQ.size() > 0) && (expQ[0].readyCyc <= cyc);
    checkOutput("rvalid", rvalid_o, frontReady);
    if (frontReady) begin
      checkOutput("rdata", rdata_o, expQ[0].rdata);
      checkOutput("err", err_o, expQ[0].err);
      checkOutput("rid", rid_o, expQ[0].rid);
      if (rready_i) begin
        lastRdata = rdata_o;
        lastErr   = err_o;
        lastRid   = rid_o;
        ent = expQ.pop_front();
        outstanding--;
      end
    end
    inRange = (addr_i < 32'(MemBytes));
    checkOutput("mem_req", mem_req_o, expGnt && inRange);
    envReq   = mem_req_o;
    envWe    = mem_we_o;
    envIdx   = mem_addr_o[9:0];
    envBe    = mem_be_o;
    envWdata = mem_wdata_o;
    if (expGnt) begin
      ent.readyCyc = cyc + 1;
      ent.rid      = aid_i;
      ent.rdata    = '0;
      ent.err      = !inRange;
      if (inRange) begin
        checkOutput("mem_addr", mem_addr_o, addr_i >> 2);
        checkOutput("mem_we", mem_we_o, we_i);
        if (we_i) begin
          checkOutput("mem_be", mem_be_o, be_i);
          checkOutput("mem_wdata", mem_wdata_o, wdata_i);
          for (int b = 0; b < 4; b++)
            if (be_i[b]) refMem[addr_i[11:2]][8*b +: 8] = wdata_i[8*b +: 8];
        end else begin
          ent.rdata = refMem[addr_i[11:2]];
        end
      end
      expQ.push_back(ent);
      outstanding++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (envReq === 1'b1) begin
      rdWord = sram[envIdx];
      if (envWe)
        for (int b = 0; b < 4; b++)
          if (envBe[b]) sram[envIdx][8*b +: 8] = envWdata[8*b +: 8];
      mem_rdata_i = rdWord;
    end
  endtask

  task automatic drainResponses();
    req_i    = 1'b0;
    rready_i = 1'b1;
    for (int k = 0; k < 12 && expQ.size() > 0; k++) runCycle();
    runCycle();
  endtask

  initial begin
    int          startGrants;
    int          idx;
    int          sel;
    logic [31:0] addr;
    logic [31:0] bpAddr [4];

    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 32'(i) * 32'h9E3779B1;
      refMem[i] = sram[i];
    end
    sram[16]   = 32'hDEADBEEF;
    refMem[16] = 32'hDEADBEEF;
    sram[2]    = 32'h11223344;
    refMem[2]  = 32'h11223344;
    mem_rdata_i = '0;
    lastGnt     = 1'b0;

    // Reset with a request pending: nothing may be granted or answered.
    rst_ni   = 1'b0;
    rready_i = 1'b1;
    applyStimulus(1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    runCycle();
    runCycle();
    rst_ni = 1'b1;
    req_i  = 1'b0;
    runCycle();

    $display("[TB] read of preloaded word");
    applyStimulus(1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    runCycle();
    checkOutput("r020_gnt_same_cycle", lastGnt, 1'b1);
    req_i = 1'b0;
    runCycle();
    checkOutput("r020_rdata", lastRdata, 32'hDEADBEEF);
    checkOutput("r020_rid", lastRid, 1'b1);
    checkOutput("r020_err", lastErr, 1'b0);

    $display("[TB] partial write then read back");
    applyStimulus(1'b1, 32'h8, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b0);
    runCycle();
    req_i = 1'b0;
    runCycle();
    checkOutput("r021_wr_err", lastErr, 1'b0);
    checkOutput("r021_wr_rdata", lastRdata, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b1);
    runCycle();
    req_i = 1'b0;
    runCycle();
    checkOutput("r021_rd_rdata", lastRdata, 32'h1122CCDD);

    $display("[TB] out-of-range access");
    applyStimulus(1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, 1'b0);
    runCycle();
    req_i = 1'b0;
    runCycle();
    checkOutput("r022_err", lastErr, 1'b1);
    checkOutput("r022_rdata", lastRdata, 32'h0);

    $display("[TB] backpressure");
    bpAddr = '{32'h40, 32'h8, 32'h100, 32'h104};
    idx = 0;
    rready_i = 1'b0;
    startGrants = dutGrants;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, bpAddr[idx], 1'b0, 4'hF, 32'h0, 1'(idx));
      runCycle();
      if (lastGnt === 1'b1) idx++;
    end
    checkOutput("r023_grants_stalled", 64'(dutGrants - startGrants), 64'd2);
    rready_i = 1'b1;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      applyStimulus(1'b1, bpAddr[idx], 1'b0, 4'hF, 32'h0, 1'(idx));
      runCycle();
      if (lastGnt === 1'b1) idx++;
    end
    drainResponses();
    checkOutput("r023_grants_total", 64'(dutGrants - startGrants), 64'd4);

    $display("[TB] streaming");
    idx = 0;
    startGrants = dutGrants;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 32'(idx) << 2, 1'b0, 4'hF, 32'h0, 1'(idx));
      runCycle();
      if (lastGnt === 1'b1) idx++;
    end
    checkOutput("r024_grants", 64'(dutGrants - startGrants), 64'd16);
    drainResponses();

    $display("[TB] random traffic");
    req_i   = 1'b0;
    lastGnt = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (req_i !== 1'b1 || lastGnt === 1'b1) begin
        if ($urandom_range(0, 3) != 0) begin
          sel = int'($urandom_range(0, 15));
          if (sel == 0)      addr = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
          else if (sel == 1) addr = $urandom | 32'h1000;
          else               addr = 32'($urandom_range(0, 63)) << 2;
          applyStimulus(1'b1, addr, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                        $urandom, 1'($urandom_range(0, 1)));
        end else begin
          req_i = 1'b0;
        end
      end
      rready_i = ($urandom_range(0, 3) != 0);
      runCycle();
    end
    drainResponses();

    $display("[TB] reset with responses outstanding");
    rready_i = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 1'b0);
    runCycle();
    applyStimulus(1'b1, 32'h44, 1'b0, 4'hF, 32'h0, 1'b1);
    runCycle();
    req_i = 1'b0;
    runCycle();
    #2;
    req_i  = 1'b1;
    rst_ni = 1'b0;
    #1;
    checkOutput("r025_rvalid_drop", rvalid_o, 1'b0);
    checkOutput("r025_gnt_in_reset", gnt_o, 1'b0);
    expQ.delete();
    outstanding = 0;
    runCycle();
    rst_ni   = 1'b1;
    req_i    = 1'b0;
    rready_i = 1'b1;
    runCycle();
    runCycle();
    applyStimulus(1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    runCycle();
    checkOutput("r025_gnt_after_release", lastGnt, 1'b1);
    req_i = 1'b0;
    runCycle();
    checkOutput("r025_rdata", lastRdata, refMem[16]);
    checkOutput("r025_rid", lastRid, 1'b1);
    drainResponses();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
